// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN to honour signed_op (signed DIV/REM); otherwise all operations are unsigned.
module seq_divider_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divzero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dzo_q, dzo_d;
    logic             done_q, done_d;

    logic             accept;
    logic             div_zero_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] fix_quo, fix_rem;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    assign accept      = (state_q == IDLE) && start;
    assign div_zero_in = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic sgn_a, sgn_b;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        logic signed [WIDTH-1:0] xs;
        xs = signed'(x);
        return neg ? WIDTH'(-xs) : x;
    endfunction

    assign sgn_a = signed_op & dividend[WIDTH-1];
    assign sgn_b = signed_op & divisor[WIDTH-1];
    assign mag_a = cond_neg(dividend, sgn_a);
    assign mag_b = cond_neg(divisor, sgn_b);

    // Divide-by-zero results bypass fix-up, so their flags are forced clear.
    assign neg_quo_d = accept ? ((sgn_a ^ sgn_b) & ~div_zero_in) : neg_quo_q;
    assign neg_rem_d = accept ? (sgn_a & ~div_zero_in) : neg_rem_q;
    assign fix_quo   = cond_neg(quo_q, neg_quo_q);
    assign fix_rem   = cond_neg(rem_q, neg_rem_q);

    always_ff @(posedge clk) begin
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign mag_a   = dividend;
    assign mag_b   = divisor;
    assign fix_quo = quo_q;
    assign fix_rem = rem_q;
`endif

    // Shifted partial remainder is WIDTH+1 bits; the top bit of the difference is the borrow.
    assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign trial_ok = ~trial[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dzo_d   = dzo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dz_d = div_zero_in;
                    if (div_zero_in) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        state_d = DONE;
                    end else begin
                        quo_d   = mag_a;
                        rem_d   = '0;
                        dvs_d   = mag_b;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = trial_ok ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d = {quo_q[WIDTH-2:0], trial_ok};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                quot_d  = fix_quo;
                remo_d  = fix_rem;
                dzo_d   = dz_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dzo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dzo_q   <= dzo_d;
            done_q  <= done_d;
        end
    end

    // Working datapath is always reloaded on an accepted start, so it carries no reset.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
        dz_q  <= dz_d;
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign divzero   = dzo_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Randomised and directed bench for seq_divider_32 against a plain-arithmetic reference model.
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divzero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prev_q, prev_r;
    logic        prev_dz;

    seq_divider_32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divzero   (divzero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: truncating division on integers, RISC-V divide-by-zero rule.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
`ifdef DIV_SIGNED_EN
        longint sa, sb, lq, lr;
`endif
        dz = (b == 32'd0);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end
`ifdef DIV_SIGNED_EN
        else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
`endif
        else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({pfx, "_done"}, {31'd0, done}, 32'd0);
        check_eq({pfx, "_quotient"}, quotient, 32'd0);
        check_eq({pfx, "_remainder"}, remainder, 32'd0);
        check_eq({pfx, "_divzero"}, {31'd0, divzero}, 32'd0);
    endtask

    // mode 0: plain, 1: start pulses while busy, 2: start during DONE, 3: reset mid-CALC
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int mode);
        logic [31:0] eq, er;
        logic        edz;
        int          lat_exp;
        bit          seen;
        int          ndone;
        ref_div(a, b, sgn, eq, er, edz);
        lat_exp = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        signed_op = sgn;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom_range(0, 1));
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        check_eq("hold_quotient", quotient, prev_q);
        seen = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                seen = 1;
                check_eq("latency", 32'(k), 32'(lat_exp));
            end else if (mode == 3 && k == 12) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check_reset_outputs("rst_mid_calc");
                ndone = 0;
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    if (done) ndone++;
                end
                check_eq("no_done_after_rst", 32'(ndone), 32'd0);
                prev_q  = 32'd0;
                prev_r  = 32'd0;
                prev_dz = 1'b0;
                return;
            end else if ((mode == 1 && (k == 5 || k == 10)) || (mode == 2 && k == lat_exp - 1)) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom | 32'd1;
                signed_op = 1'($urandom_range(0, 1));
            end
        end
        check_eq("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check_eq("quotient", quotient, eq);
            check_eq("remainder", remainder, er);
            check_eq("divzero", {31'd0, divzero}, {31'd0, edz});
            prev_q  = eq;
            prev_r  = er;
            prev_dz = edz;
            @(posedge clk);
            #1;
            check_eq("done_width", {31'd0, done}, 32'd0);
            check_eq("idle_after_done", {31'd0, busy}, 32'd0);
            check_eq("hold_remainder", remainder, prev_r);
            if (mode == 1) begin
                ndone = 0;
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    if (done) ndone++;
                end
                check_eq("extra_done", 32'(ndone), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] a, b;
        int          sel;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        prev_q    = 32'd0;
        prev_r    = 32'd0;
        prev_dz   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(32'h0000_1234, 32'd0, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0);
        run_op(32'd1000, 32'd3, 1'b0, 1);
        run_op(32'd12345, 32'hFFFF_FFF6, 1'b1, 2);
        run_op(32'd99, 32'd5, 1'b0, 3);
        run_op(32'd500, 32'd6, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(1, 15));
                4:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
